palette_lut: RTL
================

Name: palette_lut

Overview:
- Runtime-writable, multi-bank sprite palette.
- Maps a per-pixel colour index to an RGB value through a 2-stage registered lookup and flags the transparent index.
- Adds a frame-timed "hit flash" mode that forces opaque pixels to white.
- Sits between the sprite ROM/decoder index output and the VGA pixel mux. One instance serves all palettes of a sprite class, such as the per-player shield palettes.

Parameters:
- IDX_W, 4, colour-index width; entries per bank = 2**IDX_W.
- COLOR_W, 24, colour word width (RGB888).
- NUM_PAL, 4, number of palette banks; bank select width PAL_W = max(1, clog2(NUM_PAL)).
- TRANSP_IDX, 0, index reported as transparent.
- FLASH_PERIOD, 4, frames per flash on/off phase (>=1).
- FLASH_FRAMES, 32, total flash duration in frames (>=1).

Ports:
- i_clk, in, 1, pixel clock.
- i_rst, in, 1, synchronous active-high reset.
- i_valid, in, 1, lookup request this cycle.
- i_pal, in, PAL_W, bank for lookup.
- i_idx, in, IDX_W, colour index for lookup.
- o_valid, out, 1, lookup result valid; i_valid delayed 2 cycles.
- o_color, out, COLOR_W, looked-up colour.
- o_transparent, out, 1, pixel is transparent.
- i_wr_en, in, 1, palette entry write strobe.
- i_wr_pal, in, PAL_W, bank to write.
- i_wr_idx, in, IDX_W, entry to write.
- i_wr_data, in, COLOR_W, colour to write.
- i_frame_start, in, 1, one-cycle pulse per video frame.
- i_flash_start, in, 1, one-cycle pulse to start or restart flash.
- o_ready, out, 1, initialisation complete; writes and lookups accepted.
- o_flashing, out, 1, flash sequence active.

Behaviour:
- Reset: i_clk is the only clock; i_rst is synchronous and active-high.
  - While i_rst is high: o_valid=0, o_color=0, o_transparent=0, o_ready=0, o_flashing=0.
  - Pipeline valids clear; control FSM enters INIT with addr=0; flash FSM enters IDLE.
- Control FSM:
  - INIT: one entry per cycle, addr 0..NUM_PAL*2**IDX_W-1, each written to 0. After the last address, go to RUN. With defaults this is 64 cycles.
  - RUN: o_ready=1. Stays in RUN until i_rst.
  - In INIT, i_wr_en and i_valid are ignored; no o_valid pulses are produced.
  - Reset mid-INIT restarts the sweep at addr 0.
- Storage: flat array addressed {bank, idx}. A write in RUN updates the entry at the clock edge.
- Lookup pipeline (RUN only):
  - S1 registers the array read, the index and flash_on. S2 produces the outputs.
  - Latency: exactly 2 cycles. Throughput: 1 lookup per cycle, no back-pressure.
  - Read and write to the same entry in the same cycle: the lookup returns the OLD value; a lookup issued the next cycle sees the new value.
  - i_pal >= NUM_PAL (non-power-of-2 NUM_PAL): output colour 0, o_transparent=0. Writes to such banks are dropped.
- Output rules in S2, applied when the S2 valid is set:
  - idx==TRANSP_IDX: o_transparent=1, o_color=0, regardless of stored value or flash.
  - Otherwise, flash_on sampled in S1 =1: o_color = all ones (white), o_transparent=0.
  - Otherwise: o_color = stored entry, o_transparent=0.
  - When o_valid=0: o_color and o_transparent hold their last values.
- Flash FSM:
  - IDLE: on i_flash_start, go to FLASH with frame_cnt=0, phase_cnt=0, flash_on=1.
  - FLASH: o_flashing=1. On each i_frame_start:
    - frame_cnt++ and phase_cnt++.
    - When phase_cnt reaches FLASH_PERIOD: phase_cnt=0 and flash_on toggles.
    - When frame_cnt reaches FLASH_FRAMES: go to IDLE with flash_on=0.
  - i_flash_start in FLASH restarts: counters=0, flash_on=1.
  - i_flash_start and i_frame_start in the same cycle: restart wins; no count.
  - Flash FSM runs independently of INIT/RUN.
  - Counter widths hold FLASH_FRAMES and FLASH_PERIOD without wrap.
- flash_on changes take effect on lookups sampled in the cycle after the change.

Test Plan:
- Reset init: assert i_rst 3 cycles, release.
  - o_ready=0 for exactly 64 cycles, then 1.
  - Lookups issued during INIT produce no o_valid.
  - Lookup bank 2, idx 5 after ready gives o_color=24'h000000 with o_transparent=0.
- Write/read with latency: write bank 1, idx 1 = 24'hf9e746, then issue a lookup the next cycle.
  - o_valid and o_color=24'hf9e746 exactly 2 cycles after i_valid.
  - Back-to-back lookups on idx 1..15 stream one result per cycle.
- Transparency: write bank 0, idx 0 = 24'h123456, then look up idx 0.
  - o_transparent=1 and o_color=0.
  - Repeat with flash active: same result.
- Read-during-write: entry holds 24'h705d30; write 24'h4b3376 and look up the same entry in the same cycle.
  - That result is 24'h705d30; the next-cycle lookup gives 24'h4b3376.
- Flash timing (FLASH_PERIOD=4, FLASH_FRAMES=32): pulse i_flash_start, then 40 i_frame_start pulses.
  - Opaque pixels read white for frames 0-3, palette colour for frames 4-7, and alternate thereafter.
  - o_flashing falls at the 32nd frame pulse.
  - Restart at frame 10 resets to white and extends the sequence 32 frames.
- Mid-operation reset: assert i_rst during FLASH and with lookups in flight.
  - All outputs are 0 next cycle, INIT sweep repeats, previously written entries read 0.

Source files
------------

// File: rtl/palette_lut.sv
// Runtime-writable multi-bank sprite palette: 2-stage registered index-to-RGB lookup
// with transparent-index flagging and a frame-timed white "hit flash" override.
module palette_lut #(
    parameter int IDX_W        = 4,
    parameter int COLOR_W      = 24,
    parameter int NUM_PAL      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_PERIOD = 4,
    parameter int FLASH_FRAMES = 32,
    localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [PAL_W-1:0]   i_pal,
    input  logic [IDX_W-1:0]   i_idx,
    output logic               o_valid,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_transparent,
    input  logic               i_wr_en,
    input  logic [PAL_W-1:0]   i_wr_pal,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [COLOR_W-1:0] i_wr_data,
    input  logic               i_frame_start,
    input  logic               i_flash_start,
    output logic               o_ready,
    output logic               o_flashing
);
    localparam int DEPTH = NUM_PAL * (2 ** IDX_W);
    localparam int AW    = PAL_W + IDX_W;
    localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
    localparam int PC_W  = $clog2(FLASH_PERIOD + 1);
    localparam logic [PAL_W:0] NUM_PAL_L = (PAL_W + 1)'(NUM_PAL);

    localparam logic [0:0] ST_INIT = 1'b0, ST_RUN = 1'b1;
    localparam logic [0:0] FL_IDLE = 1'b0, FL_ACTIVE = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [0:0]         fl_st_q, fl_st_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [PC_W-1:0]    phase_cnt_q, phase_cnt_d;
    logic               flash_on_q, flash_on_d;
    logic               vld1_q, vld1_d;
    logic [COLOR_W-1:0] rd1_q, rd1_d;
    logic [IDX_W-1:0]   idx1_q, idx1_d;
    logic               flash1_q, flash1_d;
    logic               bad1_q, bad1_d;
    logic               valid_q, valid_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               transp_q, transp_d;

    logic [COLOR_W-1:0] mem_q [DEPTH];
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;
    logic               run, rd_ok, wr_ok;

    assign run   = (state_q == ST_RUN);
    assign rd_ok = ({1'b0, i_pal} < NUM_PAL_L);
    assign wr_ok = ({1'b0, i_wr_pal} < NUM_PAL_L);

    // The INIT sweep owns the write port; user writes only land once running.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = '0;
        state_d   = state_q;
        addr_d    = addr_q;
        if (!run) begin
            mem_we = !i_rst;
            addr_d = addr_q + 1'b1;
            if (addr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        end else if (i_wr_en && wr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = {i_wr_pal, i_wr_idx};
            mem_wdata = i_wr_data;
        end
    end

    always_comb begin
        fl_st_d     = fl_st_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        flash_on_d  = flash_on_q;
        if (i_flash_start) begin
            fl_st_d     = FL_ACTIVE;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            flash_on_d  = 1'b1;
        end else if (fl_st_q == FL_ACTIVE && i_frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            phase_cnt_d = phase_cnt_q + 1'b1;
            if (phase_cnt_d == PC_W'(FLASH_PERIOD)) begin
                phase_cnt_d = '0;
                flash_on_d  = !flash_on_q;
            end
            if (frame_cnt_d == FC_W'(FLASH_FRAMES)) begin
                fl_st_d     = FL_IDLE;
                frame_cnt_d = '0;
                phase_cnt_d = '0;
                flash_on_d  = 1'b0;
            end
        end
    end

    // S1 captures the pre-write array contents, so a same-cycle write is not visible.
    always_comb begin
        vld1_d   = i_valid && run;
        rd1_d    = rd_ok ? mem_q[{i_pal, i_idx}] : '0;
        idx1_d   = i_idx;
        flash1_d = flash_on_q;
        bad1_d   = !rd_ok;
        valid_d  = vld1_q;
        color_d  = color_q;
        transp_d = transp_q;
        if (vld1_q) begin
            transp_d = 1'b0;
            if (bad1_q)                              color_d = '0;
            else if (idx1_q == IDX_W'(TRANSP_IDX)) begin
                color_d  = '0;
                transp_d = 1'b1;
            end else if (flash1_q)                   color_d = '1;
            else                                     color_d = rd1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            addr_q      <= '0;
            fl_st_q     <= FL_IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            vld1_q      <= 1'b0;
            rd1_q       <= '0;
            idx1_q      <= '0;
            flash1_q    <= 1'b0;
            bad1_q      <= 1'b0;
            valid_q     <= 1'b0;
            color_q     <= '0;
            transp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fl_st_q     <= fl_st_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            flash_on_q  <= flash_on_d;
            vld1_q      <= vld1_d;
            rd1_q       <= rd1_d;
            idx1_q      <= idx1_d;
            flash1_q    <= flash1_d;
            bad1_q      <= bad1_d;
            valid_q     <= valid_d;
            color_q     <= color_d;
            transp_q    <= transp_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_color       = color_q;
    assign o_transparent = transp_q;
    assign o_ready       = run;
    assign o_flashing    = (fl_st_q == FL_ACTIVE);
endmodule
